// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives imem, buffers {pc, word}.
// Ports: clk, reset, imem_a/imem_rd, redirect_*, halt, inst_* handshake, fault.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fault
);

  localparam logic [29:0] MEM_LIM = 30'(MEM_WORDS);

  typedef enum logic [1:0] {
    RUN,
    HALTED,
    FAULT
  } state_t;

  state_t      state, state_n;
  logic [31:0] fetch_pc, pc_n;
  logic [1:0]  count, count_n;
  logic [31:0] e0_pc, e0_w, e1_pc, e1_w;
  logic        pop, push, oor, wr1;

  assign imem_a     = fetch_pc;
  assign inst_valid = (count != 2'd0);
  assign inst       = e0_w;
  assign inst_pc    = e0_pc;
  assign fault      = (state == FAULT);

  always_comb begin
    pop     = inst_valid & inst_ready;
    oor     = (fetch_pc[31:2] >= MEM_LIM);
    push    = 1'b0;
    state_n = state;
    if (redirect_valid) begin
      unique case (1'b1)
        (redirect_pc[1:0] != 2'b00): state_n = FAULT;
        halt:                        state_n = HALTED;
        default:                     state_n = RUN;
      endcase
    end else begin
      unique case (state)
        RUN: begin
          if (oor)
            state_n = FAULT;
          else if (halt)
            state_n = HALTED;
          else
            push = (count != 2'd2) | pop;
        end
        HALTED: if (!halt) state_n = RUN;
        FAULT:  state_n = FAULT;
        default: state_n = RUN;
      endcase
    end
    // Slot the pushed entry lands in, after any same-cycle pop.
    wr1 = ((count - {1'b0, pop}) == 2'd1);
    if (redirect_valid)
      count_n = 2'd0;
    else
      count_n = count - {1'b0, pop} + {1'b0, push};
    if (redirect_valid)
      pc_n = redirect_pc;
    else if (push)
      pc_n = fetch_pc + 32'd4;
    else
      pc_n = fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      count    <= 2'd0;
    end else begin
      state    <= state_n;
      fetch_pc <= pc_n;
      count    <= count_n;
    end
  end

  // Data registers carry no reset; validity lives entirely in count.
  always_ff @(posedge clk) begin
    if (pop) begin
      e0_pc <= e1_pc;
      e0_w  <= e1_w;
    end
    if (push && !wr1) begin
      e0_pc <= fetch_pc;
      e0_w  <= imem_rd;
    end
    if (push && wr1) begin
      e1_pc <= fetch_pc;
      e1_w  <= imem_rd;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: stream, backpressure, redirect,
// misaligned redirect, halt, mid-run reset, out-of-range fault.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        inst_ready;

  logic [31:0] imem_a, imem_rd, inst, inst_pc;
  logic        inst_valid, fault;
  logic [31:0] imem_a2, imem_rd2, inst2, inst_pc2;
  logic        inst_valid2, fault2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a[31:2] < 30'd64)
      return 32'h1000_0000 + {2'b00, a[31:2]};
    return 32'hDEAD_BEEF;
  endfunction

  assign imem_rd  = mem(imem_a);
  assign imem_rd2 = mem(imem_a2);

  imem_fetch_ctrl dut (
    .clk(clk), .reset(reset),
    .imem_a(imem_a), .imem_rd(imem_rd),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halt(halt),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .fault(fault)
  );

  imem_fetch_ctrl #(.RESET_PC(32'h0000_00F8)) dut2 (
    .clk(clk), .reset(reset),
    .imem_a(imem_a2), .imem_rd(imem_rd2),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halt(halt),
    .inst_valid(inst_valid2), .inst_ready(inst_ready),
    .inst(inst2), .inst_pc(inst_pc2), .fault(fault2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    inst_ready     = 1'b1;

    // Reset then stream
    do_reset();
    chk ("rst_a", imem_a, 32'h0);
    chkb("rst_v", inst_valid, 1'b0);
    chkb("rst_f", fault, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      chkb("str_v", inst_valid, 1'b1);
      chk ("str_pc", inst_pc, 32'(4 * k));
      chk ("str_w", inst, 32'h1000_0000 + 32'(k));
      chk ("str_a", imem_a, 32'(4 * k + 4));
    end

    // Backpressure
    inst_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) step();
    chk ("bp_a", imem_a, 32'h8);
    chkb("bp_v", inst_valid, 1'b1);
    chk ("bp_pc0", inst_pc, 32'h0);
    inst_ready = 1'b1;
    step();
    chk ("bp_pc4", inst_pc, 32'h4);
    chk ("bp_w4", inst, 32'h1000_0001);
    step();
    chk ("bp_pc8", inst_pc, 32'h8);
    step();
    chk ("bp_pc12", inst_pc, 32'hC);
    chk ("bp_a2", imem_a, 32'h14);

    // Redirect while full
    inst_ready = 1'b0;
    do_reset();
    step();
    step();
    chk ("rd_full", inst_pc, 32'h0);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    step();
    redirect_valid = 1'b0;
    chkb("rd_v0", inst_valid, 1'b0);
    chk ("rd_a", imem_a, 32'h20);
    step();
    chkb("rd_v1", inst_valid, 1'b1);
    chk ("rd_pc", inst_pc, 32'h20);
    chk ("rd_w", inst, 32'h1000_0008);

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h22;
    step();
    redirect_valid = 1'b0;
    chkb("mis_f", fault, 1'b1);
    chkb("mis_v", inst_valid, 1'b0);
    chk ("mis_a", imem_a, 32'h22);
    step();
    chkb("mis_f2", fault, 1'b1);
    chkb("mis_v2", inst_valid, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    step();
    redirect_valid = 1'b0;
    chkb("rec_f", fault, 1'b0);
    chkb("rec_v0", inst_valid, 1'b0);
    step();
    chk ("rec_pc", inst_pc, 32'h10);
    chk ("rec_w", inst, 32'h1000_0004);
    step();
    chk ("rec_pc2", inst_pc, 32'h14);

    // Halt: fill to 2, then halt for 4 cycles
    inst_ready = 1'b0;
    step();
    chk ("h_head", inst_pc, 32'h14);
    chk ("h_a0", imem_a, 32'h1C);
    halt       = 1'b1;
    inst_ready = 1'b1;
    step();
    chk ("h_pc1", inst_pc, 32'h18);
    chk ("h_a1", imem_a, 32'h1C);
    step();
    chkb("h_v2", inst_valid, 1'b0);
    step();
    step();
    chkb("h_v4", inst_valid, 1'b0);
    chk ("h_a4", imem_a, 32'h1C);
    halt = 1'b0;
    step();
    chkb("h_v5", inst_valid, 1'b0);
    step();
    chkb("h_v6", inst_valid, 1'b1);
    chk ("h_pc6", inst_pc, 32'h1C);
    step();
    chk ("h_pc7", inst_pc, 32'h20);

    // Reset mid-stream
    reset = 1'b1;
    step();
    chkb("mr_v", inst_valid, 1'b0);
    chk ("mr_a", imem_a, 32'h0);
    reset = 1'b0;

    // Out of range on the 0xF8 instance (just reset above)
    step();
    chkb("oor_v0", inst_valid2, 1'b1);
    chk ("oor_pc0", inst_pc2, 32'hF8);
    chk ("oor_w0", inst2, 32'h1000_003E);
    step();
    chk ("oor_pc1", inst_pc2, 32'hFC);
    chk ("oor_w1", inst2, 32'h1000_003F);
    chk ("oor_a", imem_a2, 32'h100);
    chkb("oor_f0", fault2, 1'b0);
    step();
    chkb("oor_f1", fault2, 1'b1);
    chkb("oor_v1", inst_valid2, 1'b0);
    chk ("oor_a1", imem_a2, 32'h100);
    step();
    chkb("oor_f2", fault2, 1'b1);
    chkb("oor_v2", inst_valid2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
